// File: rtl/mysystem_cpu_debug_scan_pkg.sv
// Shared widths, limits and the sequencer state type for the debug scan master.
package mysystem_cpu_debug_scan_pkg;

    // Width of the instruction register seen by the scan slave.
    localparam int IR_WIDTH = 2;

    // Width of the data register shifted through the slave on every command.
    localparam int DR_WIDTH = 38;

    // Bit counter width; it only has to hold indices 0..DR_WIDTH-1.
    localparam int BIT_CNT_WIDTH = 6;

    // Index of the last data bit, where the shift phase ends.
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DR_WIDTH - 1);

    // Width of the half-period counter inside the tck generator (CLK_DIV <= 255).
    localparam int HALF_CNT_WIDTH = 8;

    // One entry per virtual-JTAG phase a command walks through.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5
    } scan_state_e;

    // True when the sequencer is running a command, i.e. tck must be toggling.
    function automatic logic state_is_active(input scan_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/mysystem_cpu_debug_scan_tckgen.sv
// Divides clk into tck periods of 2*CLK_DIV cycles and flags the two edges of interest.
// The generator is parked with tck low whenever run is deasserted, so every
// command starts on the first cycle of a fresh low half-period.
module mysystem_cpu_debug_scan_tckgen
    import mysystem_cpu_debug_scan_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic period_end
);

    localparam logic [HALF_CNT_WIDTH-1:0] HALF_LAST = HALF_CNT_WIDTH'(CLK_DIV - 1);

    logic [HALF_CNT_WIDTH-1:0] half_cnt;
    logic                      phase;

    // Count clk cycles inside each half-period and flip the tck phase at its end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (!run) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            phase    <= ~phase;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // tck is the registered phase, so it never glitches.
    assign tck = phase;

    // rise marks the clk edge on which tck goes high; period_end the edge on which it drops.
    assign rise       = run && !phase && (half_cnt == HALF_LAST);
    assign period_end = run &&  phase && (half_cnt == HALF_LAST);

endmodule

// File: rtl/mysystem_cpu_debug_scan_master.sv
// Debug scan master: turns one command into a UIR/CDR/SDR/UDR/RTI walk on a
// virtual-JTAG style slave and returns the captured DR bits and ir_out.
module mysystem_cpu_debug_scan_master
    import mysystem_cpu_debug_scan_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_skip_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic                tdo,
    input  logic [IR_WIDTH-1:0] ir_out
);

    scan_state_e              state;
    scan_state_e              next_state;
    logic                     ready_en;
    logic                     accept;
    logic                     run;
    logic                     rise;
    logic                     period_end;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic [DR_WIDTH-1:0]      data_reg;
    logic [DR_WIDTH-1:0]      cap_reg;
    logic [IR_WIDTH-1:0]      ir_cap;
    logic                     last_period;

    // Ready only when parked and not in the cycle that reports a response.
    assign cmd_ready   = ready_en && (state == IDLE) && !rsp_valid;
    assign accept      = cmd_valid && cmd_ready;
    assign run         = state_is_active(state);
    assign last_period = period_end && (state == RTI);

    mysystem_cpu_debug_scan_tckgen #(
        .CLK_DIV (CLK_DIV)
    ) u_tckgen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .tck        (tck),
        .rise       (rise),
        .period_end (period_end)
    );

    // Keep cmd_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection plus the slave strobes and tdi decoded from the current phase.
    always_comb begin
        next_state     = state;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        tdi            = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = cmd_skip_ir ? CDR : UIR;
                end
            end
            UIR: begin
                vs_uir = 1'b1;
                if (period_end) begin
                    next_state = CDR;
                end
            end
            CDR: begin
                vs_cdr = 1'b1;
                if (period_end) begin
                    next_state = SDR;
                end
            end
            SDR: begin
                vs_sdr = 1'b1;
                tdi    = data_reg[bit_cnt];
                if (period_end && (bit_cnt == LAST_BIT)) begin
                    next_state = UDR;
                end
            end
            UDR: begin
                vs_udr = 1'b1;
                if (period_end) begin
                    next_state = RTI;
                end
            end
            RTI: begin
                jtag_state_rti = 1'b1;
                if (period_end) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the command on accept; ir_in only moves when the IR phase is not skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            ir_in    <= '0;
        end else if (accept) begin
            data_reg <= cmd_data;
            if (!cmd_skip_ir) begin
                ir_in <= cmd_ir;
            end
        end
    end

    // Bit counter: cleared on accept, advanced at the end of every SDR period but the last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
        end else if ((state == SDR) && period_end && (bit_cnt != LAST_BIT)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Capture tdo on each tck rise in SDR, and ir_out on the rise of the final bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_reg <= '0;
            ir_cap  <= '0;
        end else if ((state == SDR) && rise) begin
            cap_reg[bit_cnt] <= tdo;
            if (bit_cnt == LAST_BIT) begin
                ir_cap <= ir_out;
            end
        end
    end

    // Publish the response as RTI ends and hold it until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            rsp_valid <= last_period;
            if (last_period) begin
                rsp_data   <= cap_reg;
                rsp_ir_out <= ir_cap;
            end
        end
    end

endmodule

// File: tb/tb_mysystem_cpu_debug_scan_master.sv
// Self-checking bench for the debug scan master (CLK_DIV=2 main instance, CLK_DIV=1 side instance).
module tb_mysystem_cpu_debug_scan_master;

    localparam int DR_W  = 38;
    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    typedef struct {
        logic [1:0]      in_ir;
        logic            in_skip;
        logic [DR_W-1:0] in_data;
        int              tdo_mode;
        logic [DR_W-1:0] pat;
        logic [1:0]      slave_ir;
        logic            hold;
        logic [DR_W-1:0] exp_data;
        logic [1:0]      exp_irout;
        logic [1:0]      exp_irin;
        int              exp_lat;
        int              exp_sdr;
        int              exp_uir;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    logic            cmd_valid   = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_ir      = '0;
    logic            cmd_skip_ir = 1'b0;
    logic [DR_W-1:0] cmd_data    = '0;
    logic            rsp_valid;
    logic [DR_W-1:0] rsp_data;
    logic [1:0]      rsp_ir_out;
    logic            tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic [1:0]      ir_in;
    logic            tdo;
    logic [1:0]      ir_out      = '0;

    logic            cmd_valid_b = 1'b0;
    logic            cmd_ready_b;
    logic [1:0]      cmd_ir_b    = '0;
    logic [DR_W-1:0] cmd_data_b  = '0;
    logic            rsp_valid_b;
    logic [DR_W-1:0] rsp_data_b;
    logic [1:0]      rsp_ir_out_b;
    logic            tck_b, tdi_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;
    logic [1:0]      ir_in_b;
    logic            tdo_b;

    int              tdo_mode = 0;
    logic [DR_W-1:0] tdo_pat  = '0;
    int              sdr_idx  = 0;

    int checks     = 0;
    int errors     = 0;
    int excl_viol  = 0;
    int tdi_viol   = 0;
    int rsp_pulses = 0;
    logic [1:0] model_ir = '0;

    vec_t vecs[6];

    mysystem_cpu_debug_scan_master #(.CLK_DIV(DIV_A)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_skip_ir(cmd_skip_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .tck(tck), .tdi(tdi), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti), .ir_in(ir_in),
        .tdo(tdo), .ir_out(ir_out)
    );

    mysystem_cpu_debug_scan_master #(.CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b),
        .cmd_skip_ir(1'b0), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_ir_out(rsp_ir_out_b),
        .tck(tck_b), .tdi(tdi_b), .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b),
        .vs_udr(vs_udr_b), .jtag_state_rti(rti_b), .ir_in(ir_in_b),
        .tdo(tdo_b), .ir_out(2'b10)
    );

    always #5 clk = ~clk;

    // Slave model: loopback, or a fixed per-command pattern indexed by the SDR bit number.
    assign tdo   = (tdo_mode == 0) ? tdi : ((sdr_idx < DR_W) ? tdo_pat[sdr_idx] : 1'b0);
    assign tdo_b = tdi_b;

    // Count completed SDR tck rises so the pattern slave presents bit k during period k.
    always @(posedge tck) begin
        if (vs_cdr) sdr_idx <= 0;
        else if (vs_sdr) sdr_idx <= sdr_idx + 1;
    end

    // Continuous watch on strobe exclusivity, idle tdi and response pulses.
    always @(negedge clk) begin
        if (int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(jtag_state_rti) > 1)
            excl_viol <= excl_viol + 1;
        if (int'(vs_uir_b) + int'(vs_cdr_b) + int'(vs_sdr_b) + int'(vs_udr_b) + int'(rti_b) > 1)
            excl_viol <= excl_viol + 1;
        if ((!vs_sdr && tdi) || (!vs_sdr_b && tdi_b))
            tdi_viol <= tdi_viol + 1;
        if (rsp_valid)
            rsp_pulses <= rsp_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: expected outcome of one command from the protocol rules alone.
    function automatic vec_t model(input logic [1:0] ir, input logic skip, input logic [DR_W-1:0] data,
                                   input int mode, input logic [DR_W-1:0] pat, input logic [1:0] sir,
                                   input logic [1:0] prev_ir, input int div);
        vec_t v;
        int periods;
        periods     = (skip ? 0 : 1) + 1 + DR_W + 1 + 1;
        v.in_ir     = ir;
        v.in_skip   = skip;
        v.in_data   = data;
        v.tdo_mode  = mode;
        v.pat       = pat;
        v.slave_ir  = sir;
        v.hold      = 1'b0;
        v.exp_data  = (mode == 0) ? data : pat;
        v.exp_irout = sir;
        v.exp_irin  = skip ? prev_ir : ir;
        v.exp_lat   = 1 + periods * 2 * div;
        v.exp_sdr   = DR_W * 2 * div;
        v.exp_uir   = skip ? 0 : 2 * div;
        return v;
    endfunction

    function automatic vec_t mk(input logic [1:0] ir, input logic skip, input logic [DR_W-1:0] data,
                                input int mode, input logic [DR_W-1:0] pat, input logic [1:0] sir,
                                input logic hold, input logic [DR_W-1:0] ed, input logic [1:0] eio,
                                input logic [1:0] eii, input int lat, input int sdr, input int uir);
        vec_t v;
        v.in_ir = ir; v.in_skip = skip; v.in_data = data; v.tdo_mode = mode; v.pat = pat;
        v.slave_ir = sir; v.hold = hold; v.exp_data = ed; v.exp_irout = eio; v.exp_irin = eii;
        v.exp_lat = lat; v.exp_sdr = sdr; v.exp_uir = uir;
        return v;
    endfunction

    // Run one command on the CLK_DIV=2 instance (twice back to back when hold is set).
    task automatic applyStimulus(input vec_t v, input string tag);
        int wait_cnt, lat, sdr_cyc, uir_cyc, busy_cyc, reps;
        logic got;
        tdo_mode    = v.tdo_mode;
        tdo_pat     = v.pat;
        ir_out      = v.slave_ir;
        cmd_ir      = v.in_ir;
        cmd_skip_ir = v.in_skip;
        cmd_data    = v.in_data;
        cmd_valid   = 1'b1;
        reps        = v.hold ? 2 : 1;
        for (int r = 0; r < reps; r++) begin
            wait_cnt = 0;
            while (!cmd_ready && wait_cnt < 50) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!cmd_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s/accept: got cmd_ready=0 for 50 cycles, expected 1", tag);
                cmd_valid = 1'b0;
                return;
            end
            if (r == 1) checkOutput({tag, "/reaccept_wait"}, 64'(wait_cnt), 64'd0);
            lat = 0; sdr_cyc = 0; uir_cyc = 0; busy_cyc = 0; got = 1'b0;
            while (!got && lat < 2000) begin
                @(negedge clk);
                lat++;
                if (lat == 1) begin
                    if (r == reps - 1) cmd_valid = 1'b0;
                    checkOutput({tag, "/ir_in_entry"}, 64'(ir_in), 64'(v.exp_irin));
                end
                if (vs_sdr) sdr_cyc++;
                if (vs_uir) uir_cyc++;
                if (!cmd_ready) busy_cyc++;
                if (rsp_valid) got = 1'b1;
            end
            checkOutput({tag, "/latency"}, 64'(lat), 64'(v.exp_lat));
            checkOutput({tag, "/rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
            checkOutput({tag, "/rsp_ir_out"}, 64'(rsp_ir_out), 64'(v.exp_irout));
            checkOutput({tag, "/ir_in"}, 64'(ir_in), 64'(v.exp_irin));
            checkOutput({tag, "/sdr_cycles"}, 64'(sdr_cyc), 64'(v.exp_sdr));
            checkOutput({tag, "/uir_cycles"}, 64'(uir_cyc), 64'(v.exp_uir));
            checkOutput({tag, "/ready_low"}, 64'(busy_cyc), 64'(v.exp_lat));
            @(negedge clk);
            checkOutput({tag, "/rsp_pulse"}, 64'(rsp_valid), 64'd0);
            checkOutput({tag, "/rsp_hold"}, 64'(rsp_data), 64'(v.exp_data));
        end
        model_ir = v.exp_irin;
    endtask

    initial begin
        vec_t v;
        logic [63:0] rnd;
        logic [63:0] rnd2;
        int wait_cnt, lat, snap, tck_err;
        logic got;

        $display("[TB] start");
        // Directed vectors with hand-derived expectations (CLK_DIV=2).
        vecs[0] = mk(2'b01, 1'b0, 38'h2A_5555_AAAA, 0, '0, 2'b00, 1'b0,
                     38'h2A_5555_AAAA, 2'b00, 2'b01, 169, 152, 4);
        vecs[1] = mk(2'b11, 1'b0, 38'h12_3456_789A, 1, 38'h0F_0F0F_0F0F, 2'b01, 1'b0,
                     38'h0F_0F0F_0F0F, 2'b01, 2'b11, 169, 152, 4);
        vecs[2] = mk(2'b00, 1'b1, 38'h00_0000_0001, 0, '0, 2'b11, 1'b0,
                     38'h00_0000_0001, 2'b11, 2'b11, 165, 152, 0);
        vecs[3] = mk(2'b10, 1'b0, 38'h00_0000_0000, 1, 38'h3F_FFFF_FFFF, 2'b10, 1'b0,
                     38'h3F_FFFF_FFFF, 2'b10, 2'b10, 169, 152, 4);
        vecs[4] = mk(2'b01, 1'b0, 38'h15_AAAA_5555, 0, '0, 2'b00, 1'b1,
                     38'h15_AAAA_5555, 2'b00, 2'b01, 169, 152, 4);
        vecs[5] = mk(2'b11, 1'b1, 38'h20_0000_0000, 0, '0, 2'b01, 1'b0,
                     38'h20_0000_0000, 2'b01, 2'b01, 165, 152, 0);

        // Reset state while reset_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("reset/outputs",
                    64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid,
                         cmd_ready, ir_in, rsp_data, rsp_ir_out}), 64'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset/ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        checkOutput("reset/ready_after_edge", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Randomised commands against the reference model.
        for (int i = 0; i < 8; i++) begin
            rnd  = {$urandom(), $urandom()};
            rnd2 = {$urandom(), $urandom()};
            v = model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd[DR_W-1:0],
                      int'($urandom_range(0, 1)), rnd2[DR_W-1:0], 2'($urandom_range(0, 3)),
                      model_ir, DIV_A);
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        // Reset during SDR period 20: everything clears at once and no response follows.
        rnd = {$urandom(), $urandom()};
        tdo_mode = 0; cmd_ir = 2'b10; cmd_skip_ir = 1'b0; cmd_data = rnd[DR_W-1:0]; cmd_valid = 1'b1;
        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_cnt = 0;
        while (!vs_sdr && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
        checkOutput("midreset/reached_sdr", 64'(vs_sdr), 64'd1);
        repeat (20 * 2 * DIV_A + 1) @(negedge clk);
        snap = rsp_pulses;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset/outputs",
                    64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid,
                         cmd_ready, ir_in, rsp_data, rsp_ir_out}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        checkOutput("midreset/no_rsp", 64'(rsp_pulses), 64'(snap));
        model_ir = 2'b00;
        @(negedge clk);
        rnd = {$urandom(), $urandom()};
        v = model(2'b01, 1'b0, rnd[DR_W-1:0], 0, '0, 2'b11, model_ir, DIV_A);
        applyStimulus(v, "after_reset");

        // CLK_DIV=1 instance: two-cycle tck, latency 85.
        rnd = {$urandom(), $urandom()};
        cmd_ir_b = 2'b01; cmd_data_b = rnd[DR_W-1:0]; cmd_valid_b = 1'b1;
        wait_cnt = 0;
        while (!cmd_ready_b && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
        lat = 0; tck_err = 0; got = 1'b0;
        while (!got && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_valid_b = 1'b0;
            if (lat <= 84 && tck_b !== 1'((lat - 1) % 2)) tck_err++;
            if (rsp_valid_b) got = 1'b1;
        end
        checkOutput("div1/latency", 64'(lat), 64'd85);
        checkOutput("div1/tck_pattern", 64'(tck_err), 64'd0);
        checkOutput("div1/rsp_data", 64'(rsp_data_b), 64'(rnd[DR_W-1:0]));
        checkOutput("div1/rsp_ir_out", 64'(rsp_ir_out_b), 64'd2);
        checkOutput("div1/ir_in", 64'(ir_in_b), 64'd1);

        @(negedge clk);
        #1;
        checkOutput("global/strobe_exclusive", 64'(excl_viol), 64'd0);
        checkOutput("global/tdi_idle_low", 64'(tdi_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
